// File: rtl/load_tile_pair.sv
// Tile-pair loader: fetches an A tile and a B tile in lockstep from two latency-RD_LAT RAM ports.
// Optional macro LOAD_TILE_PAIR_TRANSPOSE_B_EN stores the B tile transposed.
module load_tile_pair #(
   parameter int TN     = 4,
   parameter int DW     = 16,
   parameter int AW     = 8,
   parameter int MAT_N  = 16,
   parameter int RD_LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [7:0]    block_row,
   input  logic [7:0]    block_col,
   input  logic [7:0]    block_k,
   input  logic [DW-1:0] dina,
   input  logic [DW-1:0] dinb,
   output logic [AW-1:0] addra,
   output logic [AW-1:0] addrb,
   output logic          ena,
   output logic          enb,
   output logic [DW-1:0] block_mat_a [0:TN-1][0:TN-1],
   output logic [DW-1:0] block_mat_b [0:TN-1][0:TN-1],
   output logic          busy,
   output logic          done
);

   localparam int NE = TN * TN;
   localparam int EW = (NE > 1) ? $clog2(NE) : 1;
   localparam int IW = (TN > 1) ? $clog2(TN) : 1;
   localparam logic [EW-1:0] E_LAST = EW'(NE - 1);
   localparam logic [IW-1:0] I_LAST = IW'(TN - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   state_t          state_q, state_d;
   logic [EW-1:0]   e_q, e_d, e_nxt;
   logic [7:0]      row0_q, row0_d, col0_q, col0_d, k0_q, k0_d;
   logic [AW-1:0]   addra_q, addra_d, addrb_q, addrb_d;
   logic            en_q, en_d;
   logic [IW-1:0]   iss_i_q, iss_i_d, iss_j_q, iss_j_d;
   logic [IW-1:0]   nxt_i, nxt_j;
   logic            busy_q, busy_d, done_q, done_d;

   logic            tag_v_q [RD_LAT];
   logic            tag_v_d [RD_LAT];
   logic [IW-1:0]   tag_i_q [RD_LAT];
   logic [IW-1:0]   tag_i_d [RD_LAT];
   logic [IW-1:0]   tag_j_q [RD_LAT];
   logic [IW-1:0]   tag_j_d [RD_LAT];
   logic            cap_v;
   logic [IW-1:0]   cap_i, cap_j;

   logic [DW-1:0]   tile_a_q [0:TN-1][0:TN-1];
   logic [DW-1:0]   tile_a_d [0:TN-1][0:TN-1];
   logic [DW-1:0]   tile_b_q [0:TN-1][0:TN-1];
   logic [DW-1:0]   tile_b_d [0:TN-1][0:TN-1];

   // AW-bit arithmetic wraps exactly like a full-width sum truncated mod 2^AW.
   function automatic logic [AW-1:0] lin_addr(input logic [7:0] r0, input logic [7:0] c0,
                                              input logic [IW-1:0] i, input logic [IW-1:0] j);
      return (AW'(r0) + AW'(i)) * AW'(MAT_N) + AW'(c0) + AW'(j);
   endfunction

   assign e_nxt = e_q + EW'(1);
   assign nxt_i = IW'(32'(e_nxt) / 32'(TN));
   assign nxt_j = IW'(32'(e_nxt) % 32'(TN));

   assign cap_v = tag_v_q[RD_LAT-1];
   assign cap_i = tag_i_q[RD_LAT-1];
   assign cap_j = tag_j_q[RD_LAT-1];

   always_comb begin
      state_d = state_q;
      e_d     = e_q;
      row0_d  = row0_q;
      col0_d  = col0_q;
      k0_d    = k0_q;
      addra_d = addra_q;
      addrb_d = addrb_q;
      en_d    = 1'b0;
      iss_i_d = iss_i_q;
      iss_j_d = iss_j_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = ISSUE;
               e_d     = '0;
               row0_d  = block_row;
               col0_d  = block_col;
               k0_d    = block_k;
               addra_d = lin_addr(block_row, block_k, '0, '0);
               addrb_d = lin_addr(block_k, block_col, '0, '0);
               en_d    = 1'b1;
               iss_i_d = '0;
               iss_j_d = '0;
            end
         end
         ISSUE: begin
            if (e_q == E_LAST) begin
               state_d = DRAIN;
            end else begin
               e_d     = e_nxt;
               addra_d = lin_addr(row0_q, k0_q, nxt_i, nxt_j);
               addrb_d = lin_addr(k0_q, col0_q, nxt_i, nxt_j);
               en_d    = 1'b1;
               iss_i_d = nxt_i;
               iss_j_d = nxt_j;
            end
         end
         DRAIN: begin
            if (cap_v && (cap_i == I_LAST) && (cap_j == I_LAST)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   // Stage 0 follows the registered address; the tag emerges on the capture edge.
   always_comb begin
      tag_v_d[0] = en_q;
      tag_i_d[0] = iss_i_q;
      tag_j_d[0] = iss_j_q;
      for (int unsigned k = 1; k < RD_LAT; k++) begin
         tag_v_d[k] = tag_v_q[k-1];
         tag_i_d[k] = tag_i_q[k-1];
         tag_j_d[k] = tag_j_q[k-1];
      end
   end

   always_comb begin
      tile_a_d = tile_a_q;
      tile_b_d = tile_b_q;
      if (cap_v) begin
         tile_a_d[cap_i][cap_j] = dina;
`ifdef LOAD_TILE_PAIR_TRANSPOSE_B_EN
         tile_b_d[cap_j][cap_i] = dinb;
`else
         tile_b_d[cap_i][cap_j] = dinb;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         e_q     <= '0;
         row0_q  <= '0;
         col0_q  <= '0;
         k0_q    <= '0;
         addra_q <= '0;
         addrb_q <= '0;
         en_q    <= 1'b0;
         iss_i_q <= '0;
         iss_j_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         for (int unsigned k = 0; k < RD_LAT; k++) begin
            tag_v_q[k] <= 1'b0;
            tag_i_q[k] <= '0;
            tag_j_q[k] <= '0;
         end
         for (int unsigned i = 0; i < TN; i++) begin
            for (int unsigned j = 0; j < TN; j++) begin
               tile_a_q[i][j] <= '0;
               tile_b_q[i][j] <= '0;
            end
         end
      end else begin
         state_q  <= state_d;
         e_q      <= e_d;
         row0_q   <= row0_d;
         col0_q   <= col0_d;
         k0_q     <= k0_d;
         addra_q  <= addra_d;
         addrb_q  <= addrb_d;
         en_q     <= en_d;
         iss_i_q  <= iss_i_d;
         iss_j_q  <= iss_j_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         tag_v_q  <= tag_v_d;
         tag_i_q  <= tag_i_d;
         tag_j_q  <= tag_j_d;
         tile_a_q <= tile_a_d;
         tile_b_q <= tile_b_d;
      end
   end

   assign addra       = addra_q;
   assign addrb       = addrb_q;
   assign ena         = en_q;
   assign enb         = en_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign block_mat_a = tile_a_q;
   assign block_mat_b = tile_b_q;

endmodule

// File: tb/tb_load_tile_pair.sv
// Bench for load_tile_pair: two instances (RD_LAT=1 and RD_LAT=3) share one stimulus stream,
// each checked every cycle against a timeline model plus hand-computed literals.
module tb_load_tile_pair;

   localparam int TN = 4;
   localparam int N  = TN * TN;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] block_row, block_col, block_k;
   int         cyc = 0;
   int         errors = 0;
   int         checks = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input int d, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s dut%0d: got %0d, expected %0d (cycle %0d)", name, d, act, exp, cyc);
      end
   endtask

   function automatic int addr_of(input int r0, input int c0, input int i, input int j);
      return ((r0 + i) * 16 + c0 + j) % 256;
   endfunction

   task automatic chk_zero(input int d, input logic b, input logic e, input logic eb, input logic dn,
                           input logic [7:0] aa, input logic [7:0] ab,
                           input logic [15:0] a00, input logic [15:0] a33, input logic [15:0] b33);
      check("rst_busy", d, b, 0);
      check("rst_ena", d, e, 0);
      check("rst_enb", d, eb, 0);
      check("rst_done", d, dn, 0);
      check("rst_addra", d, aa, 0);
      check("rst_addrb", d, ab, 0);
      check("rst_a00", d, a00, 0);
      check("rst_a33", d, a33, 0);
      check("rst_b33", d, b33, 0);
   endtask

   for (genvar d = 0; d < 2; d++) begin : g
      localparam int L = (d == 0) ? 1 : 3;
      logic [7:0]  addra, addrb;
      logic        ena, enb, busy, done;
      logic [15:0] dina, dinb;
      logic [15:0] bma [0:TN-1][0:TN-1];
      logic [15:0] bmb [0:TN-1][0:TN-1];
      logic [15:0] pa [L];
      logic [15:0] pb [L];

      load_tile_pair #(.TN(TN), .DW(16), .AW(8), .MAT_N(16), .RD_LAT(L)) dut (
         .clk(clk), .rst(rst_n), .start(start),
         .block_row(block_row), .block_col(block_col), .block_k(block_k),
         .dina(dina), .dinb(dinb), .addra(addra), .addrb(addrb),
         .ena(ena), .enb(enb), .block_mat_a(bma), .block_mat_b(bmb),
         .busy(busy), .done(done));

      // RAM with mem[a]=a; a disabled read returns junk so a missing enable is visible.
      always @(posedge clk) begin
         pa[0] <= ena ? {8'h00, addra} : 16'hDEAD;
         pb[0] <= enb ? {8'h00, addrb} : 16'hBEEF;
         for (int k = 1; k < L; k++) begin
            pa[k] <= pa[k-1];
            pb[k] <= pb[k-1];
         end
      end
      assign dina = pa[L-1];
      assign dinb = pb[L-1];

      int m_rel, m_r, m_c, m_k;
      bit m_act;
      int ea [TN][TN];
      int eb [TN][TN];
      int done_cnt = 0, ena_cnt = 0, busy_cnt = 0;
      int done_at [64];

      // m_rel = number of edges since the accepting edge E0 of the current load.
      always @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            m_act = 0;
            m_rel = 0;
            for (int i = 0; i < TN; i++)
               for (int j = 0; j < TN; j++) begin
                  ea[i][j] = 0;
                  eb[i][j] = 0;
               end
         end else begin
            if (!m_act || m_rel >= N + L) begin
               if (start) begin
                  m_act = 1;
                  m_rel = 0;
                  m_r = int'(block_row);
                  m_c = int'(block_col);
                  m_k = int'(block_k);
               end else begin
                  m_act = 0;
               end
            end else begin
               m_rel++;
            end
            if (m_act && m_rel >= 1 + L && m_rel <= N + L) begin
               int e;
               e = m_rel - 1 - L;
               ea[e/TN][e%TN] = addr_of(m_r, m_k, e / TN, e % TN);
`ifdef LOAD_TILE_PAIR_TRANSPOSE_B_EN
               eb[e%TN][e/TN] = addr_of(m_k, m_c, e / TN, e % TN);
`else
               eb[e/TN][e%TN] = addr_of(m_k, m_c, e / TN, e % TN);
`endif
            end
         end
      end

      always @(negedge clk) begin
         bit xb, xd, xe;
         xb = m_act && (m_rel < N + L);
         xd = m_act && (m_rel == N + L);
         xe = m_act && (m_rel < N);
         check("busy", d, busy, xb);
         check("done", d, done, xd);
         check("ena", d, ena, xe);
         check("enb", d, enb, xe);
         if (xe) begin
            check("addra", d, addra, addr_of(m_r, m_k, m_rel / TN, m_rel % TN));
            check("addrb", d, addrb, addr_of(m_k, m_c, m_rel / TN, m_rel % TN));
         end
         for (int i = 0; i < TN; i++)
            for (int j = 0; j < TN; j++) begin
               check("tile_a", d, bma[i][j], ea[i][j]);
               check("tile_b", d, bmb[i][j], eb[i][j]);
            end
         if (done) begin
            if (done_cnt < 64) done_at[done_cnt] = cyc;
            done_cnt++;
         end
         if (ena) ena_cnt++;
         if (busy) busy_cnt++;
      end
   end

   int c0, b0, b1, n0, n1, u0, u1;

   task automatic launch(input int r, input int k, input int c);
      @(negedge clk);
      block_row = 8'(r);
      block_k   = 8'(k);
      block_col = 8'(c);
      start     = 1'b1;
      b0 = g[0].done_cnt;  b1 = g[1].done_cnt;
      n0 = g[0].ena_cnt;   n1 = g[1].ena_cnt;
      u0 = g[0].busy_cnt;  u1 = g[1].busy_cnt;
      @(negedge clk);
      c0 = cyc;
   endtask

   task automatic wait_dut1_done(input int count);
      for (int n = 0; n < 120 && g[1].done_cnt < b1 + count; n++) @(negedge clk);
      repeat (5) @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      block_row = '0;
      block_col = '0;
      block_k   = '0;
      repeat (3) @(negedge clk);
      chk_zero(0, g[0].busy, g[0].ena, g[0].enb, g[0].done, g[0].addra, g[0].addrb,
               g[0].bma[0][0], g[0].bma[3][3], g[0].bmb[3][3]);
      chk_zero(1, g[1].busy, g[1].ena, g[1].enb, g[1].done, g[1].addra, g[1].addrb,
               g[1].bma[0][0], g[1].bma[3][3], g[1].bmb[3][3]);
      #2 rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single load; inputs are scrambled after E0 to prove they were latched.
      launch(4, 8, 12);
      start = 1'b0;
      block_row = 8'hAA;  block_k = 8'h55;  block_col = 8'h33;
      wait_dut1_done(1);
      check("done_count", 0, g[0].done_cnt - b0, 1);
      check("done_count", 1, g[1].done_cnt - b1, 1);
      check("latency", 0, g[0].done_at[b0] - c0, 17);
      check("latency", 1, g[1].done_at[b1] - c0, 19);
      check("ena_cycles", 0, g[0].ena_cnt - n0, 16);
      check("ena_cycles", 1, g[1].ena_cnt - n1, 16);
      check("busy_cycles", 0, g[0].busy_cnt - u0, 17);
      check("busy_cycles", 1, g[1].busy_cnt - u1, 19);
      check("a00", 0, g[0].bma[0][0], 72);
      check("a33", 0, g[0].bma[3][3], 123);
      check("a12", 1, g[1].bma[1][2], 90);
      check("b00", 0, g[0].bmb[0][0], 140);
`ifdef LOAD_TILE_PAIR_TRANSPOSE_B_EN
      check("b32", 0, g[0].bmb[3][2], 175);
      check("b32", 1, g[1].bmb[3][2], 175);
`else
      check("b32", 0, g[0].bmb[3][2], 190);
      check("b32", 1, g[1].bmb[3][2], 190);
`endif

      // start held for 36 edges: exactly one back-to-back reload per instance.
      launch(0, 4, 8);
      repeat (35) @(negedge clk);
      start = 1'b0;
      wait_dut1_done(2);
      repeat (20) @(negedge clk);
      check("b2b_count", 0, g[0].done_cnt - b0, 2);
      check("b2b_count", 1, g[1].done_cnt - b1, 2);
      check("b2b_first", 0, g[0].done_at[b0] - c0, 17);
      check("b2b_second", 0, g[0].done_at[b0+1] - c0, 35);
      check("b2b_first", 1, g[1].done_at[b1] - c0, 19);
      check("b2b_second", 1, g[1].done_at[b1+1] - c0, 39);
      check("b2b_a00", 0, g[0].bma[0][0], 4);

      // Address wrap modulo 256.
      launch(15, 15, 0);
      start = 1'b0;
      repeat (5) @(negedge clk);
      check("wrap_addra11", 0, g[0].addra, 16);
      check("wrap_addrb11", 0, g[0].addrb, 1);
      check("wrap_addra11", 1, g[1].addra, 16);
      repeat (10) @(negedge clk);
      check("wrap_addra33", 0, g[0].addra, 50);
      check("wrap_addrb33", 0, g[0].addrb, 35);
      wait_dut1_done(1);
      check("wrap_a33", 0, g[0].bma[3][3], 50);

      // Reset in cycle 7 of a load.
      launch(4, 8, 12);
      start = 1'b0;
      repeat (6) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk_zero(0, g[0].busy, g[0].ena, g[0].enb, g[0].done, g[0].addra, g[0].addrb,
               g[0].bma[0][0], g[0].bma[3][3], g[0].bmb[3][3]);
      chk_zero(1, g[1].busy, g[1].ena, g[1].enb, g[1].done, g[1].addra, g[1].addrb,
               g[1].bma[0][0], g[1].bma[3][3], g[1].bmb[3][3]);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      b0 = g[0].done_cnt;
      b1 = g[1].done_cnt;
      repeat (30) @(negedge clk);
      check("no_done_after_rst", 0, g[0].done_cnt - b0, 0);
      check("no_done_after_rst", 1, g[1].done_cnt - b1, 0);

      launch(2, 1, 3);
      start = 1'b0;
      wait_dut1_done(1);
      check("fresh_latency", 0, g[0].done_at[b0] - c0, 17);
      check("fresh_latency", 1, g[1].done_at[b1] - c0, 19);
      check("fresh_a00", 0, g[0].bma[0][0], 33);
      check("fresh_b11", 0, g[0].bmb[1][1], 36);
      check("fresh_a33", 1, g[1].bma[3][3], 84);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
